// File: rtl/uart_defs.sv
// ============================================================================
// Module      : uart_defs
// Description : Shared UART types and constants for the receive path.
// Revision    : 1.0 - initial release with sampler state and oversample defs
// ============================================================================
`default_nettype none

package uart_defs;

   localparam int UART_OVERSAMPLE     = 16;
   localparam int UART_SYNC_STAGES    = 2;
   localparam int UART_MAX_FRAME_BITS = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } SamplerState_t;

   // Keeps the bit counter terminal value reachable for out-of-range settings.
   function automatic logic [3:0] clamp_frame_bits(input logic [3:0] fb);
      if (fb == 4'd0) begin
         return 4'd1;
      end else if (fb > 4'(UART_MAX_FRAME_BITS)) begin
         return 4'(UART_MAX_FRAME_BITS);
      end else begin
         return fb;
      end
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ============================================================================
// Module      : uart_sync
// Description : N-stage flop synchroniser for idle-high asynchronous inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   // STAGES must be at least 2 for the shift below.
   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain <= {STAGES{RESET_VAL}};
      end else begin
         r_chain <= {r_chain[STAGES-2:0], d};
      end
   end

   assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// Module      : uart_rx_sampler
// Description : UART receive front end: sync, oversample, start qualify, vote.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sampler
   import uart_defs::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DIV_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_pin,
   input  logic             enable,
   input  logic [DIV_W-1:0] baud_div,
   input  logic [3:0]       frame_bits,
   output logic             bit_valid,
   output logic             bit_data,
   output logic             start_det,
   output logic             frame_error,
   output logic             break_det,
   output logic             busy
);

   localparam int              OS_W    = $clog2(OVERSAMPLE);
   localparam int              MID     = OVERSAMPLE / 2;
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_VOTE0 = OS_W'(MID - 1);
   localparam logic [OS_W-1:0] OS_VOTE1 = OS_W'(MID);
   localparam logic [OS_W-1:0] OS_DECIDE = OS_W'(MID + 1);

   SamplerState_t    r_state;
   SamplerState_t    w_state_next;

   logic             w_rx_s;
   logic             r_rx_q;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_tick_cnt;
   logic [OS_W-1:0]  r_os_cnt;
   logic [OS_W-1:0]  w_os_next;
   logic [3:0]       r_frame_bits;
   logic [3:0]       r_bit_cnt;
   logic [1:0]       r_votes;
   logic             r_all_zero;

   logic             w_tick;
   logic             w_start_edge;
   logic             w_sample;
   logic             w_decide;
   logic             w_vote;
   logic             w_last_bit;

   logic             w_bit_valid_nx;
   logic             w_bit_data_nx;
   logic             w_start_det_nx;
   logic             w_frame_error_nx;
   logic             w_break_det_nx;

   uart_sync #(
      .STAGES    (UART_SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_pin),
      .q     (w_rx_s)
   );

   // os_cnt holds the number of ticks elapsed in the current bit, so a tick
   // moving it to MID+1 is the (MID+1)-th tick after the bit began.
   assign w_tick       = (r_tick_cnt == r_div);
   assign w_os_next    = (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_W'(1);
   assign w_start_edge = enable && (r_state == IDLE) && r_rx_q && !w_rx_s;
   assign w_sample     = w_tick && ((w_os_next == OS_VOTE0) || (w_os_next == OS_VOTE1));
   assign w_decide     = enable && (r_state != IDLE) && w_tick && (w_os_next == OS_DECIDE);
   assign w_vote       = (r_votes[1] & r_votes[0]) | (r_votes[1] & w_rx_s) |
                         (r_votes[0] & w_rx_s);
   assign w_last_bit   = (r_bit_cnt == (r_frame_bits - 4'd1));
   assign busy         = (r_state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_q       <= 1'b1;
         r_div        <= '0;
         r_tick_cnt   <= '0;
         r_os_cnt     <= '0;
         r_frame_bits <= 4'd1;
         r_bit_cnt    <= '0;
         r_votes      <= 2'b11;
         r_all_zero   <= 1'b1;
      end else begin
         r_rx_q <= w_rx_s;
         if (!enable || (r_state == IDLE)) begin
            r_tick_cnt <= '0;
            r_os_cnt   <= '0;
            if (!enable) begin
               r_bit_cnt <= '0;
            end
            if (w_start_edge) begin
               r_div        <= baud_div;
               r_frame_bits <= clamp_frame_bits(frame_bits);
               r_bit_cnt    <= '0;
               r_all_zero   <= 1'b1;
            end
         end else begin
            if (w_tick) begin
               r_tick_cnt <= '0;
               r_os_cnt   <= w_os_next;
            end else begin
               r_tick_cnt <= r_tick_cnt + DIV_W'(1);
            end
            if (w_sample) begin
               r_votes <= {r_votes[0], w_rx_s};
            end
            if (w_decide && (r_state == DATA)) begin
               r_bit_cnt  <= r_bit_cnt + 4'd1;
               r_all_zero <= r_all_zero & ~w_vote;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_bit_valid_nx   = 1'b0;
      w_bit_data_nx    = 1'b0;
      w_start_det_nx   = 1'b0;
      w_frame_error_nx = 1'b0;
      w_break_det_nx   = 1'b0;
      if (!enable) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start_edge) begin
                  w_state_next = START;
               end
            end
            START: begin
               if (w_decide) begin
                  if (w_vote) begin
                     w_state_next = IDLE;
                  end else begin
                     w_start_det_nx = 1'b1;
                     w_state_next   = DATA;
                  end
               end
            end
            DATA: begin
               if (w_decide) begin
                  w_bit_valid_nx = 1'b1;
                  w_bit_data_nx  = w_vote;
                  if (w_last_bit) begin
                     w_state_next = STOP;
                  end
               end
            end
            STOP: begin
               if (w_decide) begin
                  w_frame_error_nx = !w_vote;
                  w_break_det_nx   = !w_vote && r_all_zero;
                  w_state_next     = IDLE;
               end
            end
            default: begin
               w_state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_valid   <= 1'b0;
         bit_data    <= 1'b0;
         start_det   <= 1'b0;
         frame_error <= 1'b0;
         break_det   <= 1'b0;
      end else begin
         bit_valid   <= w_bit_valid_nx;
         bit_data    <= w_bit_data_nx;
         start_det   <= w_start_det_nx;
         frame_error <= w_frame_error_nx;
         break_det   <= w_break_det_nx;
      end
   end

endmodule

`default_nettype wire
